// File: rtl/dual_deque_ctrl.sv
// Two byte deques sharing one registered-read memory, each owning half of it.
// Optional macro DUAL_DEQUE_PEEK_EN enables PEEK_FRONT/PEEK_BACK; without it they are rejected.
module dual_deque_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_sel,
  input  logic [2:0]               cmd_op,
  input  logic [7:0]               cmd_data,
  output logic                     rsp_valid,
  output logic [7:0]               rsp_data,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic                     mem_we,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  output logic [$clog2(DEPTH)-1:0] count0,
  output logic [$clog2(DEPTH)-1:0] count1
);
  localparam int AW   = $clog2(DEPTH);
  localparam int HALF = DEPTH / 2;
  localparam int PW   = AW - 1;
  localparam logic [AW-1:0] FULL_CNT = AW'(HALF);
  localparam logic [PW-1:0] CLR_LAST = {PW{1'b1}};

`ifdef DUAL_DEQUE_PEEK_EN
  localparam bit PEEK_EN = 1'b1;
`else
  localparam bit PEEK_EN = 1'b0;
`endif

  localparam logic [2:0] OP_PUSH_FRONT = 3'd0;
  localparam logic [2:0] OP_PUSH_BACK  = 3'd1;
  localparam logic [2:0] OP_POP_FRONT  = 3'd2;
  localparam logic [2:0] OP_POP_BACK   = 3'd3;
  localparam logic [2:0] OP_PEEK_FRONT = 3'd4;
  localparam logic [2:0] OP_PEEK_BACK  = 3'd5;
  localparam logic [2:0] OP_CLEAR      = 3'd6;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q [2];
  logic [PW-1:0] head_d [2];
  logic [PW-1:0] tail_q [2];
  logic [PW-1:0] tail_d [2];
  logic [AW-1:0] cnt_q  [2];
  logic [AW-1:0] cnt_d  [2];
  logic          clr_sel_q, clr_sel_d;
  logic [PW-1:0] clr_idx_q, clr_idx_d;
  logic          pend_q, pend_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;

  logic [PW-1:0] cur_head, cur_tail, head_m1, tail_m1;
  logic [AW-1:0] cur_cnt;
  logic          is_full, is_empty, accept;
  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [7:0]    mem_wdata_c;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high exactly when the controller is idle, and the response
  // for that command is a one-cycle rsp_valid pulse in the next cycle.
  assign accept   = cmd_valid && (state_q == S_IDLE);
  assign cur_head = head_q[cmd_sel];
  assign cur_tail = tail_q[cmd_sel];
  assign cur_cnt  = cnt_q[cmd_sel];
  assign head_m1  = cur_head - PW'(1);
  assign tail_m1  = cur_tail - PW'(1);
  assign is_full  = (cur_cnt == FULL_CNT);
  assign is_empty = (cur_cnt == '0);

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    clr_sel_d   = clr_sel_q;
    clr_idx_d   = clr_idx_q;
    pend_d      = 1'b0;
    rd_d        = 1'b0;
    err_d       = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pend_d = (cmd_op != OP_CLEAR);
          case (cmd_op)
            OP_PUSH_FRONT: begin
              if (is_full) err_d = 1'b1;
              else begin
                mem_we_c        = 1'b1;
                mem_addr_c      = {cmd_sel, head_m1};
                mem_wdata_c     = cmd_data;
                head_d[cmd_sel] = head_m1;
                cnt_d[cmd_sel]  = cur_cnt + AW'(1);
              end
            end
            OP_PUSH_BACK: begin
              if (is_full) err_d = 1'b1;
              else begin
                mem_we_c        = 1'b1;
                mem_addr_c      = {cmd_sel, cur_tail};
                mem_wdata_c     = cmd_data;
                tail_d[cmd_sel] = cur_tail + PW'(1);
                cnt_d[cmd_sel]  = cur_cnt + AW'(1);
              end
            end
            OP_POP_FRONT: begin
              if (is_empty) err_d = 1'b1;
              else begin
                mem_addr_c      = {cmd_sel, cur_head};
                rd_d            = 1'b1;
                head_d[cmd_sel] = cur_head + PW'(1);
                cnt_d[cmd_sel]  = cur_cnt - AW'(1);
              end
            end
            OP_POP_BACK: begin
              if (is_empty) err_d = 1'b1;
              else begin
                mem_addr_c      = {cmd_sel, tail_m1};
                rd_d            = 1'b1;
                tail_d[cmd_sel] = tail_m1;
                cnt_d[cmd_sel]  = cur_cnt - AW'(1);
              end
            end
            OP_PEEK_FRONT: begin
              if (!PEEK_EN || is_empty) err_d = 1'b1;
              else begin
                mem_addr_c = {cmd_sel, cur_head};
                rd_d       = 1'b1;
              end
            end
            OP_PEEK_BACK: begin
              if (!PEEK_EN || is_empty) err_d = 1'b1;
              else begin
                mem_addr_c = {cmd_sel, tail_m1};
                rd_d       = 1'b1;
              end
            end
            OP_CLEAR: begin
              state_d   = S_CLEAR;
              clr_sel_d = cmd_sel;
              clr_idx_d = '0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_CLEAR: begin
        // One zero write per cycle across the region, lowest address first.
        mem_we_c   = 1'b1;
        mem_addr_c = {clr_sel_q, clr_idx_q};
        clr_idx_d  = clr_idx_q + PW'(1);
        if (clr_idx_q == CLR_LAST) begin
          state_d           = S_IDLE;
          head_d[clr_sel_q] = '0;
          tail_d[clr_sel_q] = '0;
          cnt_d[clr_sel_q]  = '0;
          pend_d            = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clr_sel_q <= 1'b0;
      clr_idx_q <= '0;
      pend_q    <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      clr_sel_q <= clr_sel_d;
      clr_idx_q <= clr_idx_d;
      pend_q    <= pend_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs are forced quiet while rst is held, even before the first reset edge.
  assign cmd_ready = (state_q == S_IDLE);
  assign mem_we    = mem_we_c & ~rst;
  assign mem_addr  = rst ? '0 : mem_addr_c;
  assign mem_wdata = rst ? '0 : mem_wdata_c;
  assign rsp_valid = pend_q & ~rst;
  assign rsp_err   = err_q & ~rst;
  assign rsp_data  = (pend_q && rd_q && !rst) ? mem_rdata : 8'h00;
  assign count0    = cnt_q[0];
  assign count1    = cnt_q[1];

endmodule

// File: tb/tb_dual_deque_ctrl.sv
// Scoreboard bench for dual_deque_ctrl: queue-based reference model, behavioural memory.
module tb_dual_deque_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int HALF  = 32;
`ifdef DUAL_DEQUE_PEEK_EN
  localparam bit PEEK_EN = 1'b1;
`else
  localparam bit PEEK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_sel;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic          rsp_valid, rsp_err;
  logic [7:0]    rsp_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [AW-1:0] count0, count1;

  logic [7:0] mem [DEPTH];
  logic [7:0] dq [2][$];
  int         m_head [2];
  logic [8:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  dual_deque_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .count0(count0), .count1(count1)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got err=%0b data=%0h expected no response at %0t",
                 rsp_err, rsp_data, $time);
      end else begin
        check("rsp_err_data", {23'd0, rsp_err, rsp_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      dq[k].delete();
      m_head[k] = 0;
    end
  endtask

  task automatic check_counts();
    check("count0", count0, dq[0].size());
    check("count1", count1, dq[1].size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      if (i == 0) begin
        check("idle_mem_we", mem_we, 0);
        check("idle_mem_addr", mem_addr, 0);
        check("idle_mem_wdata", mem_wdata, 0);
      end
    end
  endtask

  // driver: one non-CLEAR command, accepted on the following rising edge
  task automatic issue(input logic s, input logic [2:0] op, input logic [7:0] d);
    logic       err, exp_we;
    logic [7:0] rd, exp_wd;
    int         exp_addr, sz;
    @(negedge clk);
    check_counts();
    cmd_valid = 1'b1; cmd_sel = s; cmd_op = op; cmd_data = d;
    sz = dq[s].size();
    err = 1'b0; rd = 8'h00; exp_we = 1'b0; exp_wd = 8'h00; exp_addr = 0;
    case (op)
      3'd0: if (sz == HALF) err = 1'b1;
            else begin
              m_head[s] = (m_head[s] + HALF - 1) % HALF;
              exp_we = 1'b1; exp_wd = d; exp_addr = s * HALF + m_head[s];
              dq[s].push_front(d);
            end
      3'd1: if (sz == HALF) err = 1'b1;
            else begin
              exp_we = 1'b1; exp_wd = d; exp_addr = s * HALF + (m_head[s] + sz) % HALF;
              dq[s].push_back(d);
            end
      3'd2: if (sz == 0) err = 1'b1;
            else begin
              exp_addr = s * HALF + m_head[s];
              rd = dq[s].pop_front();
              m_head[s] = (m_head[s] + 1) % HALF;
            end
      3'd3: if (sz == 0) err = 1'b1;
            else begin
              exp_addr = s * HALF + (m_head[s] + sz - 1) % HALF;
              rd = dq[s].pop_back();
            end
      3'd4: if (!PEEK_EN || sz == 0) err = 1'b1;
            else begin
              exp_addr = s * HALF + m_head[s];
              rd = dq[s][0];
            end
      3'd5: if (!PEEK_EN || sz == 0) err = 1'b1;
            else begin
              exp_addr = s * HALF + (m_head[s] + sz - 1) % HALF;
              rd = dq[s][sz-1];
            end
      default: err = 1'b1;
    endcase
    #1;
    check("cmd_ready", cmd_ready, 1);
    check("mem_we", mem_we, exp_we);
    if (!err) begin
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wdata", mem_wdata, exp_wd);
    end
    exp_q.push_back({err, rd});
    @(posedge clk);
  endtask

  task automatic do_clear(input logic s);
    @(negedge clk);
    check_counts();
    cmd_valid = 1'b1; cmd_sel = s; cmd_op = 3'd6; cmd_data = 8'($urandom_range(0, 255));
    #1;
    check("clr_accept_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < HALF; i++) begin
      check("clr_ready_low", cmd_ready, 0);
      check("clr_we", mem_we, 1);
      check("clr_addr", mem_addr, s * HALF + i);
      check("clr_wdata", mem_wdata, 0);
      if (i < HALF - 1) @(negedge clk);
    end
    exp_q.push_back(9'h000);
    dq[s].delete();
    m_head[s] = 0;
  endtask

  initial begin
    logic [7:0] x;
    int r;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    model_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check_counts();
    rst = 1'b0;

    // push/pop sequence on deque 0, then front-push/back-pop wrap on deque 1
    issue(0, 3'd1, 8'h11);
    issue(0, 3'd1, 8'h22);
    issue(0, 3'd2, 8'h00);
    issue(0, 3'd3, 8'h00);
    issue(1, 3'd0, 8'hA5);
    issue(1, 3'd3, 8'h00);
    idle(2);

    // fill deque 0, overflow, underflow, peeks, reserved op
    for (int i = 0; i < HALF; i++) issue(0, 3'd1, 8'($urandom_range(0, 255)));
    issue(0, 3'd1, 8'hEE);
    issue(0, 3'd0, 8'hEF);
    issue(1, 3'd2, 8'h00);
    issue(1, 3'd4, 8'h00);
    issue(0, 3'd4, 8'h00);
    issue(0, 3'd5, 8'h00);
    issue(0, 3'd7, 8'h00);

    // clear deque 1 while deque 0 is full, then deque 0
    issue(1, 3'd1, 8'h5A);
    do_clear(1);
    issue(1, 3'd1, 8'h3C);
    issue(1, 3'd3, 8'h00);
    do_clear(0);
    idle(1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      x = 8'($urandom_range(0, 255));
      if (r < 2) do_clear(1'($urandom_range(0, 1)));
      else if (r < 8) idle(1);
      else if (r < 50) issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)), x);
      else if (r < 85) issue(1'($urandom_range(0, 1)), 3'($urandom_range(2, 3)), x);
      else if (r < 96) issue(1'($urandom_range(0, 1)), 3'($urandom_range(4, 5)), x);
      else issue(1'($urandom_range(0, 1)), 3'd7, x);
    end
    idle(2);

    // reset in the middle of a CLEAR drops the operation and its response
    issue(0, 3'd1, 8'h77);
    issue(1, 3'd1, 8'h88);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_op = 3'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_we", mem_we, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_mid_ready", cmd_ready, 1);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check_counts();
    idle(3);
    issue(1, 3'd1, 8'h42);
    issue(1, 3'd2, 8'h00);
    idle(3);
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_deque_ctrl.md
DUAL_DEQUE_CTRL -- requirements
Module: dual_deque_ctrl

Interface
REQ-001 Parameter: DEPTH, default 64, total bytes of the downstream memory; it SHALL be a power of two and at least 4.
REQ-002 Derived constants: AW = clog2(DEPTH) and HALF = DEPTH/2; the design SHALL NOT expose either as a port.
REQ-003 The ports SHALL be as follows:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_sel  in  1  deque select, 0 or 1.
- cmd_op  in  3  0 PUSH_FRONT, 1 PUSH_BACK, 2 POP_FRONT, 3 POP_BACK, 4 PEEK_FRONT, 5 PEEK_BACK, 6 CLEAR, 7 reserved.
- cmd_data  in  8  push payload.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_data  out  8  pop/peek byte; 0 otherwise.
- rsp_err  out  1  command rejected.
- mem_addr  out  AW  address to the downstream registered-read byte memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, valid one cycle after the address is sampled.
- count0, count1  out  AW  occupancy of deque 0 and deque 1, range 0..HALF.

Function
REQ-004 Deque k SHALL own memory region [k*HALF, k*HALF+HALF-1]; it has a head pointer (front element) and a tail pointer (one past the back element), both modulo HALF.
REQ-005 The FSM SHALL have two states: IDLE and CLEAR; cmd_ready SHALL be 1 in IDLE and 0 in CLEAR.
REQ-006 In IDLE with no accepted command, mem_we SHALL be 0, mem_addr 0 and mem_wdata 0.
REQ-007 Accepted PUSH_BACK SHALL drive mem_we=1 at the tail address in the acceptance cycle, then increment tail and count.
REQ-008 Accepted PUSH_FRONT SHALL write to head-1 (mod HALF), then set head to that address and increment count.
REQ-009 Accepted POP_FRONT SHALL drive mem_addr=head, then increment head and decrement count.
REQ-010 Accepted POP_BACK SHALL drive mem_addr=tail-1 (mod HALF), then set tail to that address and decrement count.
REQ-011 Accepted PEEK_FRONT and PEEK_BACK SHALL address the element as for the corresponding pop and leave head, tail and count unchanged.
REQ-012 Every accepted command except CLEAR SHALL produce rsp_valid=1 exactly one cycle after acceptance.
REQ-013 For pop/peek responses, rsp_data SHALL equal mem_rdata; for push responses, rsp_data SHALL be 0 and rsp_err 0.
REQ-014 A push to a deque with count==HALF, a pop/peek from a deque with count==0, or op 7 SHALL:
- produce rsp_valid with rsp_err=1 and rsp_data=0;
- issue no memory write;
- change no pointer or count.
REQ-015 Accepted CLEAR SHALL enter CLEAR and write 0 to every address of the selected region in ascending order, one per cycle, for HALF cycles.
REQ-016 After the last CLEAR write, the FSM SHALL zero that deque's head, tail and count, pulse rsp_valid (rsp_err=0, rsp_data=0) in the following cycle, and return to IDLE.
REQ-017 During CLEAR, the other deque's state SHALL be preserved.
REQ-018 Back-to-back commands SHALL sustain one per cycle in IDLE; a pop directly after a push of the same slot SHALL return the newly pushed byte.
REQ-019 Pointer wrap SHALL stay within the region: HALF-1 increments to 0, and 0 decrements to HALF-1.

Reset
REQ-020 While rst=1, the block SHALL:
- force IDLE;
- set all pointers and counts to 0;
- drive rsp_valid=0, rsp_err=0, rsp_data=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-021 rst asserted during CLEAR or with a response pending SHALL abort the operation and drop the response; memory contents are not restored.

Configuration
REQ-022 Macro DUAL_DEQUE_PEEK_EN SHALL control the peek operations:
- defined: ops 4 and 5 behave per REQ-011;
- undefined: ops 4 and 5 are treated as op 7 (error response, no state change).

Verification
REQ-023 Reset, then PUSH_BACK 0x11, 0x22 to deque 0, then POP_FRONT -> rsp_data 0x11, then POP_BACK -> rsp_data 0x22, with count0 going 1, 2, 1, 0.
REQ-024 DEPTH=64: PUSH_FRONT 0xA5 to empty deque 1 -> write at mem_addr 63; POP_BACK -> read at addr 63, rsp_data 0xA5.
REQ-025 Push 32 bytes to deque 0 -> count0=32; a 33rd push -> rsp_err=1 with no mem_we; POP_FRONT on empty deque 1 -> rsp_err=1.
REQ-026 CLEAR deque 1 -> cmd_ready low for 32 cycles, mem_we at addrs 32..63 with data 0, then rsp_valid, count1=0, and count0 unchanged.
REQ-027 With DUAL_DEQUE_PEEK_EN: PEEK_FRONT -> front byte returned, count unchanged. Without the macro: the same command -> rsp_err=1.
REQ-028 rst asserted mid-CLEAR -> next cycle IDLE, cmd_ready=1, both counts 0, no rsp_valid.
